// File: rtl/mem_bus_interface_pkg.sv
// Shared state encodings, byte-enable codes, error bit indices and lane helpers for mem_bus_interface.
package mem_bus_interface_pkg;

  typedef enum logic [1:0] {
    MBI_IDLE   = 2'd0,
    MBI_SETUP  = 2'd1,
    MBI_ACCESS = 2'd2,
    MBI_HOLD   = 2'd3
  } mbi_state_t;

  localparam logic [1:0] MBI_BE_LO   = 2'b01;
  localparam logic [1:0] MBI_BE_HI   = 2'b10;
  localparam logic [1:0] MBI_BE_WORD = 2'b11;

  localparam logic [1:0] MBI_ERR_MISALIGN = 2'd0;
  localparam logic [1:0] MBI_ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] MBI_ERR_OVERRUN  = 2'd2;

  function automatic logic [1:0] mbi_byte_enable(input logic byte_acc, input logic lane);
    if (!byte_acc) return MBI_BE_WORD;
    return lane ? MBI_BE_HI : MBI_BE_LO;
  endfunction

  function automatic logic [7:0] mbi_byte_lane(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state down-counter plus saturating MEM_READY-low timeout counter for one access.
module mem_wait_timer #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  input  logic ready,
  output logic expired,
  output logic timed_out
);

  localparam int WW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_STATES);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] to_cnt;
  logic [TW:0]   to_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else if (load) begin
      wait_cnt <= WAIT_INIT;
      to_cnt   <= '0;
    end else if (enable) begin
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WW'(1);
      end else if (!ready && to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  assign to_next = {1'b0, to_cnt} + (TW + 1)'(1);
  assign expired = (wait_cnt == '0);
  // Abort on the ready-low cycle whose increment would reach the limit.
  assign timed_out = enable && expired && !ready && (to_next >= {1'b0, TO_LIMIT});

endmodule

// File: rtl/mem_bus_interface.sv
// Memory bus interface: latches a CPU request and runs a wait-state-aware cycle on a synchronous memory bus.
module mem_bus_interface
  import mem_bus_interface_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WR,
  input  logic        BYTE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DIN,
  output logic [15:0] DATA_IN,
  output logic        ACK,
  output logic        BUSY,
  output logic [2:0]  ERR,
  output logic [14:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  input  logic [15:0] MEM_DIN,
  output logic [1:0]  MEM_BE,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic        MEM_READY
);

  mbi_state_t state, state_next;
  logic wr_q, byte_q, lane_q, misalign_q, timeout_q, overrun_q;
  logic expired, timed_out;
  logic accept, capture, abort;

  assign accept  = (state == MBI_IDLE) && REQ;
  assign capture = (state == MBI_ACCESS) && expired && MEM_READY;
  assign abort   = (state == MBI_ACCESS) && timed_out;

  mem_wait_timer #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT)
  ) u_timer (
    .clk      (CLK),
    .reset    (RESET),
    .load     (state == MBI_SETUP),
    .enable   (state == MBI_ACCESS),
    .ready    (MEM_READY),
    .expired  (expired),
    .timed_out(timed_out)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= MBI_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MBI_IDLE:   if (REQ) state_next = MBI_SETUP;
      MBI_SETUP:  state_next = MBI_ACCESS;
      MBI_ACCESS: if (capture || abort) state_next = MBI_HOLD;
      MBI_HOLD:   state_next = MBI_IDLE;
      default:    state_next = MBI_IDLE;
    endcase
  end

  always_comb begin
    ACK    = (state == MBI_HOLD);
    BUSY   = (state != MBI_IDLE);
    MEM_RD = (state == MBI_ACCESS) && !wr_q;
    MEM_WR = (state == MBI_ACCESS) && wr_q;
    ERR    = 3'b000;
    ERR[MBI_ERR_OVERRUN] = overrun_q;
    if (state == MBI_HOLD) begin
      ERR[MBI_ERR_TIMEOUT]  = timeout_q;
      ERR[MBI_ERR_MISALIGN] = misalign_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      lane_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_BE     <= 2'b00;
      MEM_DOUT   <= '0;
      DATA_IN    <= '0;
    end else begin
      if (accept) begin
        wr_q       <= WR;
        byte_q     <= BYTE;
        lane_q     <= ADDR[0];
        misalign_q <= !BYTE && ADDR[0];
        timeout_q  <= 1'b0;
        MEM_ADDR   <= ADDR[15:1];
        MEM_BE     <= mbi_byte_enable(BYTE, ADDR[0]);
        MEM_DOUT   <= BYTE ? {DIN[7:0], DIN[7:0]} : DIN;
      end
      if (REQ && state != MBI_IDLE) overrun_q <= 1'b1;
      if (capture && !wr_q) begin
        DATA_IN <= byte_q ? {8'h00, mbi_byte_lane(MEM_DIN, lane_q)} : MEM_DIN;
      end
      if (abort) begin
        timeout_q <= 1'b1;
        if (!wr_q) DATA_IN <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface using a default instance and a WAIT_STATES=2/TIMEOUT=4 instance.
module tb_mem_bus_interface;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset, req, wr, bt, mem_ready;
  logic [15:0] addr, din, mem_din;
  bit sel;

  logic [15:0] a_data_in, b_data_in, a_mem_dout, b_mem_dout;
  logic [14:0] a_mem_addr, b_mem_addr;
  logic [2:0]  a_err, b_err;
  logic [1:0]  a_mem_be, b_mem_be;
  logic a_ack, b_ack, a_busy, b_busy, a_mem_rd, b_mem_rd, a_mem_wr, b_mem_wr;

  logic [15:0] data_in, mem_dout;
  logic [14:0] mem_addr;
  logic [2:0]  err;
  logic [1:0]  mem_be;
  logic ack, busy, mem_rd, mem_wr;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int lo_start = 0, lo_end = 0, inj_cyc = -1;

  always #5 clk = ~clk;

  mem_bus_interface u_a (
    .CLK(clk), .RESET(reset), .REQ(req & ~sel), .WR(wr), .BYTE(bt), .ADDR(addr), .DIN(din),
    .DATA_IN(a_data_in), .ACK(a_ack), .BUSY(a_busy), .ERR(a_err), .MEM_ADDR(a_mem_addr),
    .MEM_DOUT(a_mem_dout), .MEM_DIN(mem_din), .MEM_BE(a_mem_be), .MEM_RD(a_mem_rd),
    .MEM_WR(a_mem_wr), .MEM_READY(mem_ready)
  );

  mem_bus_interface #(.WAIT_STATES(2), .TIMEOUT(4)) u_b (
    .CLK(clk), .RESET(reset), .REQ(req & sel), .WR(wr), .BYTE(bt), .ADDR(addr), .DIN(din),
    .DATA_IN(b_data_in), .ACK(b_ack), .BUSY(b_busy), .ERR(b_err), .MEM_ADDR(b_mem_addr),
    .MEM_DOUT(b_mem_dout), .MEM_DIN(mem_din), .MEM_BE(b_mem_be), .MEM_RD(b_mem_rd),
    .MEM_WR(b_mem_wr), .MEM_READY(mem_ready)
  );

  assign data_in  = sel ? b_data_in  : a_data_in;
  assign mem_dout = sel ? b_mem_dout : a_mem_dout;
  assign mem_addr = sel ? b_mem_addr : a_mem_addr;
  assign err      = sel ? b_err      : a_err;
  assign mem_be   = sel ? b_mem_be   : a_mem_be;
  assign ack      = sel ? b_ack      : a_ack;
  assign busy     = sel ? b_busy     : a_busy;
  assign mem_rd   = sel ? b_mem_rd   : a_mem_rd;
  assign mem_wr   = sel ? b_mem_wr   : a_mem_wr;

  // Called at a negedge in an IDLE cycle; returns at the negedge of the SETUP cycle.
  task automatic send_req(input bit s, input bit w, input bit b, input logic [15:0] a,
                          input logic [15:0] d, input bit push, input exp_t e);
    sel = s; wr = w; bt = b; addr = a; din = d; req = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Observes the bus until ACK, then steps into the following IDLE cycle.
  task automatic wait_ack(input int budget, output bit got, output int lat, output logic [15:0] d,
                          output logic [2:0] e, output int rd_cnt, output int wr_cnt);
    got = 0; lat = 0; d = '0; e = '0; rd_cnt = 0; wr_cnt = 0;
    for (int c = 1; c <= budget; c++) begin
      if (mem_rd === 1'b1) rd_cnt++;
      if (mem_wr === 1'b1) wr_cnt++;
      if (ack === 1'b1) begin
        got = 1; lat = c; d = data_in; e = err;
        break;
      end
      req = (c == inj_cyc);
      mem_ready = !(c >= lo_start && c < lo_end);
      @(negedge clk);
    end
    req = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_sb(input string tag, input bit got, input int lat, input logic [15:0] d,
                          input logic [2:0] e);
    exp_t x;
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL %s_ack: got ack=%0d queued=%0d want ack=1", tag, got, sb.size());
      if (sb.size() != 0) x = sb.pop_front();
      return;
    end
    x = sb.pop_front();
    n_cmp++; if (lat != x.lat) begin n_bad++; $display("FAIL %s_lat: got %0d want %0d", tag, lat, x.lat); end
    n_cmp++; if (d !== x.data) begin n_bad++; $display("FAIL %s_data: got %h want %h", tag, d, x.data); end
    n_cmp++; if (e !== x.err) begin n_bad++; $display("FAIL %s_err: got %b want %b", tag, e, x.err); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 0; wr = 0; bt = 0; addr = '0; din = '0; mem_din = '0; mem_ready = 1; sel = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_ack !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_ack_busy: got %b%b want 00", a_ack, a_busy); end
    n_cmp++; if (a_data_in !== 16'h0000) begin n_bad++; $display("FAIL rst_data: got %h want 0000", a_data_in); end
    n_cmp++; if (a_err !== 3'b000 || b_err !== 3'b000) begin n_bad++; $display("FAIL rst_err: got %b/%b want 000", a_err, b_err); end
    n_cmp++; if (a_mem_addr !== 15'h0 || a_mem_dout !== 16'h0 || a_mem_be !== 2'b00) begin
      n_bad++; $display("FAIL rst_bus: got %h %h %b want 0 0 00", a_mem_addr, a_mem_dout, a_mem_be); end
    n_cmp++; if (a_mem_rd !== 1'b0 || a_mem_wr !== 1'b0 || b_mem_rd !== 1'b0) begin
      n_bad++; $display("FAIL rst_strobe: got %b%b%b want 000", a_mem_rd, a_mem_wr, b_mem_rd); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_read();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'hBEEF; lo_start = 0; lo_end = 0; inj_cyc = -1;
    send_req(0, 0, 0, 16'h0124, 16'h0000, 1, '{16'hBEEF, 3'b000, 3});
    n_cmp++; if (mem_addr !== 15'h0092) begin n_bad++; $display("FAIL wr_addr: got %h want 0092", mem_addr); end
    n_cmp++; if (mem_be !== 2'b11) begin n_bad++; $display("FAIL wr_be: got %b want 11", mem_be); end
    n_cmp++; if (mem_rd !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_setup: got rd=%b busy=%b want 0 1", mem_rd, busy); end
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("word_read", got, lat, d, e);
    n_cmp++; if (rc != 1 || wc != 0) begin n_bad++; $display("FAIL wr_strobes: got rd=%0d wr=%0d want 1 0", rc, wc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_byte_write();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'h7777;
    send_req(0, 1, 1, 16'h0011, 16'h12AB, 1, '{16'hBEEF, 3'b000, 3});
    n_cmp++; if (mem_dout !== 16'hABAB) begin n_bad++; $display("FAIL bw_dout: got %h want ABAB", mem_dout); end
    n_cmp++; if (mem_be !== 2'b10) begin n_bad++; $display("FAIL bw_be: got %b want 10", mem_be); end
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("byte_write", got, lat, d, e);
    n_cmp++; if (wc != 1 || rc != 0) begin n_bad++; $display("FAIL bw_strobes: got wr=%0d rd=%0d want 1 0", wc, rc); end
  endtask

  task automatic test_back_to_back();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'h5AC3;
    send_req(0, 0, 1, 16'h0011, 16'h0000, 1, '{16'h005A, 3'b000, 3});
    n_cmp++; if (mem_be !== 2'b10) begin n_bad++; $display("FAIL br_hi_be: got %b want 10", mem_be); end
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("byte_read_hi", got, lat, d, e);
    send_req(0, 0, 1, 16'h0010, 16'h0000, 1, '{16'h00C3, 3'b000, 3});
    n_cmp++; if (mem_be !== 2'b01 || mem_addr !== 15'h0008) begin
      n_bad++; $display("FAIL br_lo_bus: got be=%b addr=%h want 01 0008", mem_be, mem_addr); end
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("byte_read_lo", got, lat, d, e);
  endtask

  task automatic test_wait_overrun();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'h1357; lo_start = 4; lo_end = 7; inj_cyc = 3;
    send_req(1, 0, 0, 16'h0040, 16'h0000, 1, '{16'h1357, 3'b100, 8});
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("wait_overrun", got, lat, d, e);
    n_cmp++; if (rc != 6) begin n_bad++; $display("FAIL wo_rd_cycles: got %0d want 6", rc); end
    n_cmp++; if (err !== 3'b100) begin n_bad++; $display("FAIL wo_sticky: got %b want 100", err); end
    inj_cyc = -1;
  endtask

  task automatic test_timeout();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'hFFFF; lo_start = 1; lo_end = 1000;
    send_req(1, 0, 0, 16'h0003, 16'h0000, 1, '{16'h0000, 3'b111, 8});
    n_cmp++; if (mem_addr !== 15'h0001) begin n_bad++; $display("FAIL to_addr: got %h want 0001", mem_addr); end
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("timeout", got, lat, d, e);
    lo_start = 0; lo_end = 0;
  endtask

  task automatic test_reset_mid();
    bit got; int lat, rc, wc; logic [15:0] d; logic [2:0] e;
    mem_din = 16'h4444;
    send_req(0, 0, 0, 16'h0200, 16'h0000, 0, '{16'h0000, 3'b000, 0});
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rm_in_access: got rd=%b want 1", mem_rd); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || mem_rd !== 1'b0 || ack !== 1'b0) begin
      n_bad++; $display("FAIL rm_idle: got busy=%b rd=%b ack=%b want 0 0 0", busy, mem_rd, ack); end
    n_cmp++; if (data_in !== 16'h0000 || mem_addr !== 15'h0) begin
      n_bad++; $display("FAIL rm_regs: got data=%h addr=%h want 0000 0000", data_in, mem_addr); end
    n_cmp++; if (b_err !== 3'b000) begin n_bad++; $display("FAIL rm_overrun_clr: got %b want 000", b_err); end
    reset = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_no_ack: got ack=%b busy=%b want 0 0", ack, busy); end
    mem_din = 16'hBEEF;
    send_req(0, 0, 0, 16'h0124, 16'h0000, 1, '{16'hBEEF, 3'b000, 3});
    wait_ack(40, got, lat, d, e, rc, wc);
    check_sb("after_reset", got, lat, d, e);
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_back_to_back();
    test_wait_overrun();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Memory bus interface sitting directly downstream of the CPU data-bus multiplexer. It captures the selected 16-bit data-bus value as write data, together with an address and access type. It then runs a multi-cycle, wait-state-aware read or write cycle on the external synchronous memory bus. Read data is returned as a registered word with a one-cycle acknowledge.

## Interface
Parameters:
- WAIT_STATES, default 0: fixed extra cycles spent in ACCESS before MEM_READY is sampled.
- TIMEOUT, default 255: maximum MEM_READY-low cycles after wait states expire before the access is aborted.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  1  single-cycle access request; honoured only in IDLE.
- WR  input  1  1 = write, 0 = read; sampled with REQ.
- BYTE  input  1  1 = byte access, 0 = word access; sampled with REQ.
- ADDR  input  16  byte address; sampled with REQ.
- DIN  input  16  write data from the data-bus mux DOUT; sampled with REQ.
- DATA_IN  output  16  registered read result; reset 16'h0000.
- ACK  output  1  one-cycle completion pulse; reset 0.
- BUSY  output  1  high from the cycle after an accepted REQ until the cycle after ACK; reset 0.
- ERR  output  3  {OVERRUN, TIMEOUT, MISALIGN}; OVERRUN is sticky, others are valid with ACK; reset 3'b000.
- MEM_ADDR  output  15  word address to memory; reset 0.
- MEM_DOUT  output  16  write data to memory; reset 0.
- MEM_DIN  input  16  read data from memory.
- MEM_BE  output  2  byte enables {high, low}; reset 2'b00.
- MEM_RD  output  1  read strobe; reset 0.
- MEM_WR  output  1  write strobe; reset 0.
- MEM_READY  input  1  memory ready; sampled only in ACCESS after wait states expire.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE: REQ=1 latches WR, BYTE, ADDR and DIN, then moves to SETUP.
- SETUP: drives MEM_ADDR=ADDR[15:1], MEM_BE and MEM_DOUT; strobes stay low. Always moves to ACCESS next cycle.
- ACCESS:
  - Asserts MEM_RD or MEM_WR.
  - Wait counter loads WAIT_STATES on entry and decrements to 0.
  - At 0, if MEM_READY=1, goes to HOLD; on a read, DATA_IN is loaded on this edge.
  - At 0, if MEM_READY=0, the timeout counter increments. When it reaches TIMEOUT, goes to HOLD with TIMEOUT set and DATA_IN=16'h0000.
- HOLD: strobes low, ACK=1 for exactly one cycle, then returns to IDLE.
- Byte write: MEM_DOUT = {DIN[7:0], DIN[7:0]}; MEM_BE = ADDR[0] ? 2'b10 : 2'b01.
- Byte read: DATA_IN = {8'h00, ADDR[0] ? MEM_DIN[15:8] : MEM_DIN[7:0]} (zero-extended).
- Word access: MEM_BE=2'b11. If ADDR[0]=1, ADDR[0] is ignored (access is even-aligned) and MISALIGN is reported with ACK.
- REQ while not IDLE: request ignored, OVERRUN set. OVERRUN clears only on RESET.
- Write leaves DATA_IN unchanged.

## Timing
- WAIT_STATES=0 with MEM_READY=1, REQ at edge 0:
  - SETUP during cycle 1, ACCESS cycle 2, HOLD/ACK cycle 3, IDLE cycle 4.
  - Latency REQ→ACK is 3 cycles. Each wait state or ready-low cycle adds 1.
- Earliest next REQ is accepted in the cycle after ACK (cycle 4).
- MEM_ADDR, MEM_BE and MEM_DOUT are stable from SETUP through HOLD. Strobes are high only in ACCESS.
- RESET mid-access: next edge forces IDLE, all outputs to reset values, strobes low; no ACK is issued.
- Timeout counter width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
- MEM_READY=1 before the wait counter expires is ignored.

## Structure
- Constants go in the shared constants.v: state encodings (MBI_IDLE, MBI_SETUP, MBI_ACCESS, MBI_HOLD), BE codes (MBI_BE_LO, MBI_BE_HI, MBI_BE_WORD) and ERR bit indices.
- One sub-module, mem_wait_timer, holds the wait-state down-counter plus the saturating timeout counter. It has inputs load/enable/ready and outputs expired/timed_out.
- Top level holds the FSM, request latches, byte steering and output registers.

## Test plan
- Word read, WAIT_STATES=0, ADDR=16'h0124, MEM_DIN=16'hBEEF, READY=1 → MEM_ADDR=15'h0092, MEM_BE=2'b11, ACK on cycle 3, DATA_IN=16'hBEEF, ERR=0.
- Byte write ADDR=16'h0011, DIN=16'h12AB → MEM_DOUT=16'hABAB, MEM_BE=2'b10, MEM_WR high exactly 1 cycle, DATA_IN unchanged.
- Byte read ADDR=16'h0011, MEM_DIN=16'h5AC3 → DATA_IN=16'h005A; ADDR=16'h0010 → 16'h00C3.
- WAIT_STATES=2, MEM_READY low 3 cycles after expiry → ACK at cycle 8; second REQ sent during ACCESS is ignored and ERR[2] (OVERRUN) latches 1.
- TIMEOUT=4, MEM_READY held 0 → ACK with ERR[1]=1 and DATA_IN=16'h0000; word access at ADDR=16'h0003 → MEM_ADDR=15'h0001 and ERR[0]=1.
- RESET asserted in ACCESS → next cycle state IDLE, MEM_RD=0, BUSY=0, no ACK; new REQ then completes normally.
